// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling at CLK_PER_BAUD clocks per bit.
// Define UART_RX_PARITY_EN to expect an even-parity bit after data bit 7.
module uart_rx #(
    parameter int CLK_PER_BAUD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int HALF = CLK_PER_BAUD / 2;
    localparam int CW   = $clog2(CLK_PER_BAUD);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BAUD - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
    localparam logic [2:0] BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd5;
    logic                  par_bit;
`endif

    logic          rx_m;
    logic          rx_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            rx_byte   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        // a start bit gone high by mid-bit was a glitch
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        shift   <= {rx_s, shift[7:1]};
                        cnt     <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        par_bit <= rx_s;
                        cnt     <= '0;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (^shift ^ par_bit) begin
                                parity_err <= 1'b1;
                            end else begin
                                rx_byte  <= shift;
                                rx_valid <= 1'b1;
                            end
`else
                            rx_byte  <= shift;
                            rx_valid <= 1'b1;
`endif
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver: the downstream counterpart of the team's `uart` transmitter. It consumes the `tx` line of that block and rebuilds 8-bit bytes.
- Frame format: 8N1 (1 start bit, 8 data bits LSB first, 1 stop bit, line idles high).
- `rx` is oversampled on the system clock at `CLK_PER_BAUD` cycles per bit and sampled at mid-bit.
- Received bytes are presented with a one-cycle valid strobe, for a FIFO or command parser to consume.

Parameters:
- CLK_PER_BAUD, 4, clock cycles per bit period; legal values ≥ 4; HALF = CLK_PER_BAUD/2 (integer divide).

Ports:
- clk  input  1  system clock, one clock domain
- rst  input  1  asynchronous, active-high reset
- rx  input  1  asynchronous serial input line, idle high
- rx_byte  output  8  last correctly framed byte; held until the next good byte
- rx_valid  output  1  one-cycle pulse when rx_byte updates
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low
- parity_err  output  1  one-cycle pulse on parity mismatch (feature only; otherwise constant 0)
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, synchronizer flops=1, cnt=0, bit_idx=0, shift=0. Outputs: rx_byte=8'h00, rx_valid=0, frame_err=0, parity_err=0, busy=0.
- Synchronizer: 2-flop, reset to 1. All decisions use the synchronized output rx_s, which lags rx by 2 cycles.
- States: IDLE, START, DATA, (PARITY), STOP, BREAK. cnt is the bit-timing counter.
- IDLE: when rx_s==0, go to START with cnt=0.
- START: cnt increments each cycle. At cnt==HALF-1:
  - rx_s==0: go to DATA, cnt=0, bit_idx=0.
  - rx_s==1: treat as a glitch and return to IDLE. No outputs are produced.
- DATA: cnt increments. At cnt==CLK_PER_BAUD-1:
  - shift <= {rx_s, shift[7:1]} (LSB first); cnt=0; bit_idx++.
  - After bit_idx 7 is sampled, go to PARITY if the feature is enabled, otherwise to STOP.
- STOP: at cnt==CLK_PER_BAUD-1, sample rx_s:
  - rx_s==1: rx_byte<=shift, rx_valid=1 for exactly one cycle (the cycle after the sample), go to IDLE.
  - rx_s==0: frame_err=1 for one cycle, rx_byte unchanged, go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A held-low line (break) produces exactly one frame_err and nothing else.
- Back-to-back frames: IDLE detects the next start edge on the cycle after leaving STOP. No extra idle time is required beyond the stop bit.
- Latency: rx_valid asserts 2 (sync) + HALF + 9×CLK_PER_BAUD + 1 cycles after the falling edge of the start bit on rx, ±1 cycle for edge alignment.
- rx_valid, frame_err and parity_err are mutually exclusive in any one cycle.
- Reset mid-frame: abort immediately; the partial byte is discarded and no strobe is produced.
- No backpressure: the consumer must accept rx_valid in the cycle it is asserted.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows data bit 7 (PARITY state, sampled at cnt==CLK_PER_BAUD-1).
  - The STOP state still runs.
  - If the stop bit is good but ^shift ^ parity_bit != 0, pulse parity_err instead of rx_valid and leave rx_byte unchanged.
  - A stop-bit error takes precedence and produces frame_err only.
- Undefined: no PARITY state; parity_err is tied to 0; the frame is 10 bits.

Test Plan:
- Byte '0' (8'h30) driven at CLK_PER_BAUD=4 with ideal timing → one rx_valid pulse, rx_byte=8'h30, busy low afterwards, frame_err never asserted.
- Loopback of the team's uart transmitter sending 8'h55 then 8'hAA back-to-back → two rx_valid pulses, rx_byte=8'h55 then 8'hAA, separated by exactly 10×CLK_PER_BAUD cycles.
- rx low for 1 cycle (glitch), then high → START aborts to IDLE, no rx_valid or frame_err, busy high for at most HALF+1 cycles.
- Frame 8'hA5 with stop bit forced 0 and line held low for 40 cycles, then released, then a good 8'h3C → one frame_err pulse; rx_byte stays 8'h00 until 8'h3C is received with rx_valid.
- rst asserted mid-data of 8'hFF, released, then 8'h12 sent → no strobe for the aborted frame; rx_byte=8'h12 after the next rx_valid.
- With UART_RX_PARITY_EN: 8'h07 with parity bit 1 → rx_valid, rx_byte=8'h07. 8'h07 with parity bit 0 → parity_err pulse, rx_byte unchanged.
